// File: rtl/core_alu_mc.sv
// Selen EX-stage execute unit: single-cycle ALU and branch compares plus iterative
// shift-add multiply and restoring divide, behind a valid/ready request/response pair.
module core_alu_mc #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [4:0]       req_op,
  input  logic [2:0]       req_brnch_cnd,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [XLEN-1:0]  resp_result,
  output logic             resp_brnch_taken,
  output logic             resp_err,
  output logic [TAG_W-1:0] resp_tag
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_SLT = 5'd5,  OP_SLTU = 5'd6, OP_SLL = 5'd7;
  localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA = 5'd9,  OP_AM = 5'd10,  OP_MUL = 5'd11;
  localparam logic [4:0] OP_MULH = 5'd12, OP_MULHU = 5'd13, OP_MULHSU = 5'd14, OP_DIV = 5'd15;
  localparam logic [4:0] OP_DIVU = 5'd16, OP_REM = 5'd17, OP_REMU = 5'd18;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic              neg_q, sel_q;
  logic [TAG_W-1:0]  tag_q;
  logic              resp_val_q, resp_brnch_taken_q, resp_err_q;
  logic [XLEN-1:0]   resp_result_q;
  logic [TAG_W-1:0]  resp_tag_q;

  logic              accept, is_brnch, is_mul, is_div, is_rem, is_hi;
  logic              s1_neg, s2_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   abs1, abs2, div_corner_res, alu_res;
  logic              alu_err, brnch_taken;
  logic [XLEN:0]     am_sum, mul_sum, div_trial, div_rem;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_acc_d, div_acc_d, mul_fix;
  logic [XLEN-1:0]   mul_res, div_res, div_q, div_r;
  logic [SHW-1:0]    shamt;

  assign req_rdy  = (state_q == IDLE) & (~resp_val_q | resp_rdy);
  assign accept   = req_val & req_rdy & ~flush;
  assign is_brnch = req_brnch_cnd[2];
  assign is_mul   = ~is_brnch & (req_op >= OP_MUL) & (req_op <= OP_MULHSU);
  assign is_div   = ~is_brnch & (req_op >= OP_DIV) & (req_op <= OP_REMU);
  assign is_rem   = (req_op == OP_REM) | (req_op == OP_REMU);
  assign is_hi    = (req_op == OP_MULH) | (req_op == OP_MULHU) | (req_op == OP_MULHSU);
  assign s1_neg   = req_src1[XLEN-1] & ((req_op == OP_MULH) | (req_op == OP_MULHSU) |
                                        (req_op == OP_DIV) | (req_op == OP_REM));
  assign s2_neg   = req_src2[XLEN-1] & ((req_op == OP_MULH) | (req_op == OP_DIV) | (req_op == OP_REM));
  assign abs1     = s1_neg ? -req_src1 : req_src1;
  assign abs2     = s2_neg ? -req_src2 : req_src2;
  assign div_zero = (req_src2 == '0);
  assign div_ovf  = ((req_op == OP_DIV) | (req_op == OP_REM)) & (req_src1 == MIN_VAL) & (&req_src2);
  assign div_corner_res = div_zero ? (is_rem ? req_src1 : '1) : (is_rem ? '0 : MIN_VAL);
  assign shamt    = req_src2[SHW-1:0];
  assign am_sum   = {1'b0, req_src1} + {1'b0, req_src2};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (req_op)
      OP_ADD:  alu_res = req_src1 + req_src2;
      OP_SUB:  alu_res = req_src1 - req_src2;
      OP_AND:  alu_res = req_src1 & req_src2;
      OP_OR:   alu_res = req_src1 | req_src2;
      OP_XOR:  alu_res = req_src1 ^ req_src2;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(req_src1) < $signed(req_src2)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, req_src1 < req_src2};
      OP_SLL:  alu_res = req_src1 << shamt;
      OP_SRL:  alu_res = req_src1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(req_src1) >>> shamt);
      OP_AM:   alu_res = am_sum[XLEN:1];
      OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    brnch_taken = 1'b0;
    case (req_brnch_cnd[1:0])
      2'b00:   brnch_taken = (req_src1 == req_src2);
      2'b01:   brnch_taken = (req_src1 != req_src2);
      2'b10:   brnch_taken = $signed(req_src1) < $signed(req_src2);
      default: brnch_taken = req_src1 < req_src2;
    endcase
  end

  // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};
  assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = div_trial >= {1'b0, opb_q};
  assign div_rem   = div_ge ? div_trial - {1'b0, opb_q} : div_trial;
  assign div_acc_d = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], div_ge};

  // The final step's result is sign-fixed in the same edge so latency stays XLEN+1
  assign mul_fix = neg_q ? -mul_acc_d : mul_acc_d;
  assign mul_res = sel_q ? mul_fix[2*XLEN-1:XLEN] : mul_fix[XLEN-1:0];
  assign div_q   = div_acc_d[XLEN-1:0];
  assign div_r   = div_acc_d[2*XLEN-1:XLEN];
  assign div_res = sel_q ? (neg_q ? -div_r : div_r) : (neg_q ? -div_q : div_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      acc_q              <= '0;
      opb_q              <= '0;
      neg_q              <= 1'b0;
      sel_q              <= 1'b0;
      tag_q              <= '0;
      resp_val_q         <= 1'b0;
      resp_result_q      <= '0;
      resp_brnch_taken_q <= 1'b0;
      resp_err_q         <= 1'b0;
      resp_tag_q         <= '0;
    end else if (flush) begin
      state_q    <= IDLE;
      resp_val_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      if (resp_val_q && resp_rdy) resp_val_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (is_mul || (is_div && !div_zero && !div_ovf)) begin
            state_q <= is_mul ? MUL : DIV;
            cnt_q   <= CW'(XLEN);
            acc_q   <= {{XLEN{1'b0}}, is_mul ? abs2 : abs1};
            opb_q   <= is_mul ? abs1 : abs2;
            neg_q   <= is_rem ? s1_neg : (s1_neg ^ s2_neg);
            sel_q   <= is_hi | is_rem;
            tag_q   <= req_tag;
          end else begin
            resp_val_q         <= 1'b1;
            resp_result_q      <= is_brnch ? '0 : (is_div ? div_corner_res : alu_res);
            resp_brnch_taken_q <= is_brnch & brnch_taken;
            resp_err_q         <= ~is_brnch & alu_err;
            resp_tag_q         <= req_tag;
          end
        end
        MUL, DIV: begin
          acc_q <= (state_q == MUL) ? mul_acc_d : div_acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q            <= IDLE;
            resp_val_q         <= 1'b1;
            resp_result_q      <= (state_q == MUL) ? mul_res : div_res;
            resp_brnch_taken_q <= 1'b0;
            resp_err_q         <= 1'b0;
            resp_tag_q         <= tag_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_val         = resp_val_q;
  assign resp_result      = resp_result_q;
  assign resp_brnch_taken = resp_brnch_taken_q;
  assign resp_err         = resp_err_q;
  assign resp_tag         = resp_tag_q;
endmodule

// File: tb/tb_core_alu_mc.sv
// Bench for core_alu_mc: directed corner cases, handshake/flush/reset checks and
// randomized ops compared against a plain-arithmetic reference model.
module tb_core_alu_mc;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, req_val, req_rdy, resp_val, resp_rdy;
  logic [4:0]       req_op;
  logic [2:0]       req_brnch_cnd;
  logic [XLEN-1:0]  req_src1, req_src2, resp_result;
  logic [TAG_W-1:0] req_tag, resp_tag;
  logic             resp_brnch_taken, resp_err;

  int checks = 0;
  int passed = 0;

  core_alu_mc #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_brnch_cnd(req_brnch_cnd),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_result(resp_result),
    .resp_brnch_taken(resp_brnch_taken), .resp_err(resp_err), .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Reference behaviour straight from the op table, using 64-bit products and SV division
  function automatic void refModel(input logic [4:0] op, input logic [2:0] cnd,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic taken,
                                   output logic err, output int lat);
    logic signed [31:0] sa, sb;
    logic [63:0] p;
    logic [32:0] s;
    sa = a; sb = b; res = '0; taken = 1'b0; err = 1'b0; lat = 1;
    if (cnd[2]) begin
      case (cnd[1:0])
        2'd0: taken = (a == b);
        2'd1: taken = (a != b);
        2'd2: taken = (sa < sb);
        default: taken = (a < b);
      endcase
    end else begin
      case (op)
        5'd0:  res = a + b;
        5'd1:  res = a - b;
        5'd2:  res = a & b;
        5'd3:  res = a | b;
        5'd4:  res = a ^ b;
        5'd5:  res = (sa < sb) ? 32'd1 : 32'd0;
        5'd6:  res = (a < b) ? 32'd1 : 32'd0;
        5'd7:  res = a << b[4:0];
        5'd8:  res = a >> b[4:0];
        5'd9:  res = sa >>> b[4:0];
        5'd10: begin s = {1'b0, a} + {1'b0, b}; res = s[32:1]; end
        5'd11: begin p = {32'b0, a} * {32'b0, b}; res = p[31:0]; lat = 33; end
        5'd12: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; res = p[63:32]; lat = 33; end
        5'd13: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; lat = 33; end
        5'd14: begin p = {{32{a[31]}}, a} * {32'b0, b}; res = p[63:32]; lat = 33; end
        5'd15: begin
          if (b == 0) res = '1;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
          else begin res = sa / sb; lat = 33; end
        end
        5'd16: begin
          if (b == 0) res = '1;
          else begin res = a / b; lat = 33; end
        end
        5'd17: begin
          if (b == 0) res = a;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = '0;
          else begin res = sa % sb; lat = 33; end
        end
        5'd18: begin
          if (b == 0) res = a;
          else begin res = a % b; lat = 33; end
        end
        default: err = 1'b1;
      endcase
    end
  endfunction

  task automatic issueRequest(input logic [4:0] op, input logic [2:0] cnd,
                              input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int n;
    req_op = op; req_brnch_cnd = cnd; req_src1 = a; req_src2 = b; req_tag = tag; req_val = 1'b1;
    n = 0;
    while (!req_rdy && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_rdy) checkOutput("reqRdyTimeout", 64'(req_rdy), 64'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [2:0] cnd,
                               input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                               output logic [31:0] res, output logic taken, output logic err,
                               output logic [3:0] rtag, output int lat);
    issueRequest(op, cnd, a, b, tag);
    lat = 1;
    while (!resp_val && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!resp_val) checkOutput("respTimeout", 64'(resp_val), 64'd1);
    res = resp_result; taken = resp_brnch_taken; err = resp_err; rtag = resp_tag;
  endtask

  task automatic checkDirected(input string name, input logic [4:0] op, input logic [2:0] cnd,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input logic expTaken, input int expLat);
    logic [31:0] res; logic taken, err; logic [3:0] rtag; int lat;
    applyStimulus(op, cnd, a, b, 4'hA, res, taken, err, rtag, lat);
    checkOutput({name, ".res"}, 64'(res), 64'(expRes));
    checkOutput({name, ".taken"}, 64'(taken), 64'(expTaken));
    checkOutput({name, ".lat"}, 64'(lat), 64'(expLat));
  endtask

  task automatic drainResponse();
    resp_rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res, expRes, a, b;
    logic taken, err, expTaken, expErr;
    logic [3:0] rtag, tag;
    logic [4:0] op;
    logic [2:0] cnd;
    int lat, expLat, cnt;

    rst = 1'b1; flush = 1'b0; req_val = 1'b0; resp_rdy = 1'b1;
    req_op = '0; req_brnch_cnd = '0; req_src1 = '0; req_src2 = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetOutputs", {resp_val, resp_brnch_taken, resp_err, req_rdy, resp_tag, resp_result},
                {1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0});
    rst = 1'b0;

    checkDirected("addOvf", 5'd0, 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
    checkDirected("am", 5'd10, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
    checkDirected("sra31", 5'd9, 3'b000, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1);
    checkDirected("bltu", 5'd0, 3'b111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    checkDirected("blt", 5'd0, 3'b110, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
    checkDirected("beq", 5'd3, 3'b100, 32'd5, 32'd5, 32'h0, 1'b1, 1);
    checkDirected("mulh", 5'd12, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
    checkDirected("mulLow", 5'd11, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 33);
    checkDirected("mulhu", 5'd13, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    checkDirected("div", 5'd15, 3'b000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    checkDirected("rem", 5'd17, 3'b000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    checkDirected("divuZero", 5'd16, 3'b000, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1'b0, 1);
    checkDirected("remZero", 5'd17, 3'b000, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0, 1);
    checkDirected("divOvf", 5'd15, 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    applyStimulus(5'd25, 3'b000, 32'h5, 32'h6, 4'h3, res, taken, err, rtag, lat);
    checkOutput("illegal", {err, rtag, lat[7:0], res}, {1'b1, 4'h3, 8'd1, 32'h0});

    // Held response: outputs frozen and no new requests while the consumer stalls
    drainResponse();
    resp_rdy = 1'b0;
    applyStimulus(5'd0, 3'b000, 32'd3, 32'd4, 4'd5, res, taken, err, rtag, lat);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stallHold", {resp_val, req_rdy, resp_tag, resp_result}, {1'b1, 1'b0, 4'd5, 32'd7});
      @(posedge clk); #1;
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    checkOutput("stallRelease", {resp_val, req_rdy}, {1'b0, 1'b1});

    for (int i = 0; i < 10; i++) begin
      req_val = 1'b1; req_op = 5'd0; req_brnch_cnd = 3'b000;
      req_src1 = 32'(i); req_src2 = 32'd100; req_tag = TAG_W'(i);
      checkOutput("b2bReqRdy", 64'(req_rdy), 64'd1);
      @(posedge clk); #1;
      checkOutput("b2bResp", {resp_val, resp_tag, resp_result}, {1'b1, TAG_W'(i), 32'(i + 100)});
    end
    req_val = 1'b0;
    drainResponse();

    issueRequest(5'd13, 3'b000, 32'hDEAD_BEEF, 32'h1234_5678, 4'h7);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flushIdle", {req_rdy, resp_val}, {1'b1, 1'b0});
    cnt = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (resp_val) cnt++; end
    checkOutput("flushNoResp", 64'(cnt), 64'd0);
    req_val = 1'b1; req_op = 5'd0; req_brnch_cnd = 3'b000; req_src1 = 32'd1; req_src2 = 32'd2;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_val = 1'b0;
    checkOutput("flushDrop", 64'(resp_val), 64'd0);

    applyStimulus(5'd0, 3'b000, 32'd1, 32'd1, 4'd3, res, taken, err, rtag, lat);
    drainResponse();
    issueRequest(5'd15, 3'b000, 32'd100, 32'd7, 4'h9);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncReset", {resp_val, resp_brnch_taken, resp_err, req_rdy, resp_tag, resp_result},
                {1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0});
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(5'd1, 3'b000, 32'd10, 32'd3, 4'h2, res, taken, err, rtag, lat);
    checkOutput("afterReset", {rtag, lat[7:0], res}, {4'h2, 8'd1, 32'd7});

    for (int i = 0; i < 60; i++) begin
      op  = 5'($urandom_range(0, 20));
      cnd = ($urandom_range(0, 3) == 0) ? {1'b1, 2'($urandom_range(0, 3))} : 3'($urandom_range(0, 3));
      a   = pickOperand();
      b   = pickOperand();
      tag = 4'($urandom_range(0, 15));
      refModel(op, cnd, a, b, expRes, expTaken, expErr, expLat);
      applyStimulus(op, cnd, a, b, tag, res, taken, err, rtag, lat);
      checkOutput($sformatf("rnd%0d op%0d cnd%0d res", i, op, cnd), 64'(res), 64'(expRes));
      checkOutput($sformatf("rnd%0d flags", i), {taken, err, rtag}, {expTaken, expErr, tag});
      checkOutput($sformatf("rnd%0d lat", i), 64'(lat), 64'(expLat));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
